// File: rtl/spinner_quad_decoder_if.sv
// Purpose : bundles the spinner decoder's sample/control inputs and decoded outputs.
// Ports   : master drives ce/spinner/rd/err_clr; slave (the decoder) drives
//           delta_q/delta_nz/position/step_pulse/step_dir/err_cnt.
interface spinner_quad_decoder_if #(
   parameter int DELTA_W = 8,
   parameter int POS_W   = 12,
   parameter int ERR_W   = 4
);
   logic               ce;
   logic [1:0]         spinner;
   logic               rd;
   logic               err_clr;
   logic [DELTA_W-1:0] delta_q;
   logic               delta_nz;
   logic [POS_W-1:0]   position;
   logic               step_pulse;
   logic               step_dir;
   logic [ERR_W-1:0]   err_cnt;

   modport master (
      output ce, spinner, rd, err_clr,
      input  delta_q, delta_nz, position, step_pulse, step_dir, err_cnt
   );

   modport slave (
      input  ce, spinner, rd, err_clr,
      output delta_q, delta_nz, position, step_pulse, step_dir, err_cnt
   );
endinterface

// File: rtl/spinner_quad_decoder.sv
// Purpose : quadrature spinner {B,A} -> synchronised, glitch-filtered steps, saturating read-and-clear
//           delta, wrapping absolute position, step pulse/direction and saturating illegal-transition count.
// Latency : raw edge -> step_pulse = SYNC_STAGES clocks + FILTER_TICKS ce ticks + 1 clock; no backpressure.
// Ports   : clk_48m, reset (async active-low); bus.slave carries ce/spinner/rd/err_clr in and
//           delta_q/delta_nz/position/step_pulse/step_dir/err_cnt out.
module spinner_quad_decoder #(
   parameter int SYNC_STAGES  = 2,
   parameter int FILTER_TICKS = 4,
   parameter int DELTA_W      = 8,
   parameter int POS_W        = 12,
   parameter int ERR_W        = 4
) (
   input  logic                   clk_48m,
   input  logic                   reset,
   spinner_quad_decoder_if.slave  bus
);
   localparam int CNT_W = $clog2(FILTER_TICKS + 1);
   localparam logic [CNT_W-1:0]   FT      = CNT_W'(FILTER_TICKS);
   localparam logic [DELTA_W-1:0] ACC_MAX = {1'b0, {(DELTA_W-1){1'b1}}};
   localparam logic [DELTA_W-1:0] ACC_MIN = {1'b1, {(DELTA_W-1){1'b0}}};

   // Position of a phase value along the +1 sequence 00->10->11->01.
   function automatic logic [1:0] phase_idx(input logic [1:0] p);
      return {p[0], p[0] ^ p[1]};
   endfunction

   logic [SYNC_STAGES-1:0][1:0] sync_q;
   logic [1:0]         cand_q, cand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         phase_q, phase_d;
   logic               init_q, init_d;
   logic [DELTA_W-1:0] acc_q, acc_d;
   logic [DELTA_W-1:0] delta_out_q, delta_out_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               pulse_q, pulse_d;
   logic               dir_q, dir_d;

   logic [1:0]         sync_out;
   logic               accept;
   logic [1:0]         idx_diff;
   logic               step_inc, step_dec, illegal;
   logic [DELTA_W-1:0] acc_sat, step_val;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // While the init flag is set, a settled value is accepted even if it matches the
   // reset phase, so the first stable reading after reset always becomes the reference.
   assign accept   = (cnt_q == FT) && (init_q || (cand_q != phase_q));
   assign idx_diff = phase_idx(cand_q) - phase_idx(phase_q);
   assign step_inc = accept && !init_q && (idx_diff == 2'd1);
   assign step_dec = accept && !init_q && (idx_diff == 2'd3);
   assign illegal  = accept && !init_q && (idx_diff == 2'd2);

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (bus.ce) begin
         if (sync_out != cand_q) begin
            cand_d = sync_out;
            cnt_d  = CNT_W'(1);
         end else if (cnt_q < FT) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      phase_d = accept ? cand_q : phase_q;
      init_d  = accept ? 1'b0 : init_q;

      acc_sat = acc_q;
      if (step_inc && (acc_q != ACC_MAX)) begin
         acc_sat = acc_q + DELTA_W'(1);
      end else if (step_dec && (acc_q != ACC_MIN)) begin
         acc_sat = acc_q - DELTA_W'(1);
      end

      step_val = '0;
      if (step_inc) begin
         step_val = DELTA_W'(1);
      end else if (step_dec) begin
         step_val = '1;
      end

      // A read hands out the pre-step total and restarts from this cycle's step,
      // so a coinciding step lands in the next read exactly once.
      delta_out_d = bus.rd ? acc_q : delta_out_q;
      acc_d       = bus.rd ? step_val : acc_sat;

      pos_d = pos_q;
      if (step_inc) begin
         pos_d = pos_q + POS_W'(1);
      end else if (step_dec) begin
         pos_d = pos_q - POS_W'(1);
      end

      err_d = err_q;
      if (illegal) begin
         if (bus.err_clr) begin
            err_d = ERR_W'(1);
         end else if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
         end
      end else if (bus.err_clr) begin
         err_d = '0;
      end

      pulse_d = step_inc || step_dec;
      dir_d   = step_inc ? 1'b1 : (step_dec ? 1'b0 : dir_q);
   end

   always_ff @(posedge clk_48m or negedge reset) begin
      if (!reset) begin
         sync_q      <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         phase_q     <= '0;
         init_q      <= 1'b1;
         acc_q       <= '0;
         delta_out_q <= '0;
         pos_q       <= '0;
         err_q       <= '0;
         pulse_q     <= 1'b0;
         dir_q       <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.spinner};
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         init_q      <= init_d;
         acc_q       <= acc_d;
         delta_out_q <= delta_out_d;
         pos_q       <= pos_d;
         err_q       <= err_d;
         pulse_q     <= pulse_d;
         dir_q       <= dir_d;
      end
   end

   assign bus.delta_q    = delta_out_q;
   assign bus.delta_nz   = (acc_q != '0);
   assign bus.position   = pos_q;
   assign bus.step_pulse = pulse_q;
   assign bus.step_dir   = dir_q;
   assign bus.err_cnt    = err_q;
endmodule
